// File: rtl/aer_out_4ph_if.sv
// ----------------------------------------------------------------------------
// aer_out_4ph_if
// Bus bundle for aer_out_4ph: the incoming valid/ready event stream from the
// bridge and the outgoing asynchronous 4-phase AER bus towards the device.
//
//   in_addr  [31:0]       event address from the bridge (oaer_addr)
//   in_vld                event valid
//   in_rdy                buffer can accept an event this cycle
//   aer_addr [ADDR_W-1:0] external AER address (registered)
//   aer_req               4-phase request (registered)
//   aer_ack               4-phase acknowledge from the device (asynchronous)
//
// slave  : the aer_out_4ph block (consumes the stream, drives the AER bus)
// master : the environment (bridge side plus external device)
// ----------------------------------------------------------------------------
interface aer_out_4ph_if #(
  parameter int ADDR_W = 32
);
  logic [31:0]       in_addr;
  logic              in_vld;
  logic              in_rdy;
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_req;
  logic              aer_ack;

  modport master (
    output in_addr, in_vld, aer_ack,
    input  in_rdy, aer_addr, aer_req
  );

  modport slave (
    input  in_addr, in_vld, aer_ack,
    output in_rdy, aer_addr, aer_req
  );
endinterface

// File: rtl/aer_out_4ph.sv
// ----------------------------------------------------------------------------
// aer_out_4ph
// Output stage of the SpiNNaker-to-neuromorphic bridge. Buffers events from
// the 32-bit valid/ready AER stream in a small FIFO and replays them on an
// external asynchronous 4-phase AER bus (address + req, ack from device).
// The address is presented SETUP_CYC cycles before req rises; a handshake
// that sees no acknowledge for TIMEOUT cycles is abandoned, counted and
// flagged.
//
// Ports
//   clk_32       single clock for all logic
//   rst          asynchronous, active-low reset
//   bus          aer_out_4ph_if.slave: in_addr/in_vld/in_rdy stream and
//                aer_addr/aer_req/aer_ack 4-phase bus
//   err_clr      synchronous clear of timeout_err and drop_cnt
//   timeout_err  sticky flag, set by any handshake timeout
//   drop_cnt     saturating count of timed-out events
//   fifo_lvl     current FIFO occupancy (0 .. 2**FIFO_AW)
//   dbg_state    FSM state: IDLE=0, SETUP=1, REQ=2, RELEASE=3
// ----------------------------------------------------------------------------
module aer_out_4ph #(
  parameter int ADDR_W    = 32,
  parameter int FIFO_AW   = 3,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                clk_32,
  input  logic                rst,
  aer_out_4ph_if.slave        bus,
  input  logic                err_clr,
  output logic                timeout_err,
  output logic [7:0]          drop_cnt,
  output logic [FIFO_AW:0]    fifo_lvl,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SCW   = $clog2(SETUP_CYC + 1);

  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [SCW-1:0]   SC_INIT  = SCW'(SETUP_CYC);
  localparam logic [15:0]      TO_LIM   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // FIFO storage and control
  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_lvl;
  logic               r_in_rdy;

  // Handshake FSM
  state_t             r_state;
  logic [SCW-1:0]     r_setup_cnt;
  logic [15:0]        r_to_cnt;
  logic               r_aer_req;
  logic [ADDR_W-1:0]  r_aer_addr;
  logic               r_timeout_err;
  logic [7:0]         r_drop_cnt;

  // Acknowledge synchroniser; r_ack_s2 is the synchronised ack
  logic               r_ack_s1;
  logic               r_ack_s2;

  logic               w_push;
  logic               w_pop;
  logic [FIFO_AW:0]   w_lvl_nxt;
  logic [31:0]        w_head;
  logic [SCW-1:0]     w_setup_dec;
  logic [15:0]        w_to_inc;
  logic [7:0]         w_drop_base;

  assign w_push      = bus.in_vld && r_in_rdy;
  assign w_pop       = (r_state == ST_IDLE) && (r_lvl != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_setup_dec = r_setup_cnt - SCW'(1);
  assign w_to_inc    = r_to_cnt + 16'd1;
  // A timeout in the same cycle as err_clr counts from zero, so the set wins.
  assign w_drop_base = err_clr ? 8'd0 : r_drop_cnt;

  always_comb begin
    w_lvl_nxt = r_lvl;
    if (w_push && !w_pop) begin
      w_lvl_nxt = r_lvl + LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_lvl_nxt = r_lvl - LVL_ONE;
    end
  end

  // ---- stage: FIFO write (data path, not reset) ----
  always_ff @(posedge clk_32) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_addr;
    end
  end

  // ---- stage: FIFO pointers / occupancy ----
  // in_rdy is registered from the next occupancy, so it never depends
  // combinationally on in_vld; it stays low throughout reset.
  always_ff @(posedge clk_32 or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lvl    <= '0;
      r_in_rdy <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_lvl    <= w_lvl_nxt;
      r_in_rdy <= (w_lvl_nxt != LVL_FULL);
    end
  end

  // ---- stage: ack synchroniser ----
  always_ff @(posedge clk_32 or negedge rst) begin
    if (!rst) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= bus.aer_ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // ---- stage: 4-phase handshake FSM ----
  always_ff @(posedge clk_32 or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_setup_cnt   <= '0;
      r_to_cnt      <= '0;
      r_aer_req     <= 1'b0;
      r_aer_addr    <= '0;
      r_timeout_err <= 1'b0;
      r_drop_cnt    <= 8'd0;
    end else begin
      // A timeout below overrides this clear within the same cycle.
      if (err_clr) begin
        r_timeout_err <= 1'b0;
        r_drop_cnt    <= 8'd0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_aer_addr  <= w_head[ADDR_W-1:0];
            r_setup_cnt <= SC_INIT;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Hitting zero on the SETUP_CYC-th edge after the address load.
          r_setup_cnt <= w_setup_dec;
          if (w_setup_dec == '0) begin
            r_aer_req <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (r_ack_s2) begin
            r_aer_req <= 1'b0;
            r_state   <= ST_RELEASE;
          end else begin
            r_to_cnt <= w_to_inc;
            if (w_to_inc == TO_LIM) begin
              // Event is abandoned, never retried.
              r_aer_req     <= 1'b0;
              r_timeout_err <= 1'b1;
              r_drop_cnt    <= sat_inc8(w_drop_base);
              r_state       <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (!r_ack_s2) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_rdy   = r_in_rdy;
  assign bus.aer_addr = r_aer_addr;
  assign bus.aer_req  = r_aer_req;
  assign timeout_err  = r_timeout_err;
  assign drop_cnt     = r_drop_cnt;
  assign fifo_lvl     = r_lvl;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_aer_out_4ph.sv
// ----------------------------------------------------------------------------
// tb_aer_out_4ph
// Scoreboard bench for aer_out_4ph. Every accepted event is pushed onto an
// expected-address queue; an independent monitor pops it whenever aer_req
// rises. An emulated AER device acknowledges after a programmable delay or
// stays mute to provoke timeouts. A short TIMEOUT keeps the run brief.
// ----------------------------------------------------------------------------
module tb_aer_out_4ph;
  localparam int ADDR_W    = 32;
  localparam int FIFO_AW   = 3;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 40;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic               clk_32 = 1'b0;
  logic               rst_n  = 1'b0;
  logic               err_clr = 1'b0;
  logic               timeout_err;
  logic [7:0]         drop_cnt;
  logic [FIFO_AW:0]   fifo_lvl;
  logic [1:0]         dbg_state;

  aer_out_4ph_if #(.ADDR_W(ADDR_W)) bus ();

  aer_out_4ph #(
    .ADDR_W   (ADDR_W),
    .FIFO_AW  (FIFO_AW),
    .SETUP_CYC(SETUP_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_32     (clk_32),
    .rst        (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .timeout_err(timeout_err),
    .drop_cnt   (drop_cnt),
    .fifo_lvl   (fifo_lvl),
    .dbg_state  (dbg_state)
  );

  always #5 clk_32 = ~clk_32;

  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          exp_drop = 0;
  bit          exp_err  = 1'b0;
  bit          dev_on   = 1'b1;
  int          dev_dly  = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- emulated AER device ----------------
  initial begin : device
    int dly;
    bus.aer_ack = 1'b0;
    dly = 0;
    forever begin
      @(negedge clk_32);
      #2;
      if (!rst_n) begin
        bus.aer_ack = 1'b0;
        dly = 0;
      end else if ((bus.aer_req != bus.aer_ack) && (dev_on || !bus.aer_req)) begin
        if (dly >= dev_dly) begin
          bus.aer_ack = bus.aer_req;
          dly = 0;
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   n_acc, n_pop, setup_run, hi_cnt;
  bit   pend, prev_req, acked, first;
  logic [1:0] prev_state;

  always @(negedge clk_32) begin
    if (!rst_n) begin
      n_acc = 0; n_pop = 0; setup_run = 0; hi_cnt = 0;
      pend = 0; prev_req = 0; acked = 0; first = 1;
      prev_state = 2'd0;
      exp_err = 0; exp_drop = 0;
    end else begin
      n_acc += int'(pend);
      if (dbg_state == 2'd1 && prev_state != 2'd1) n_pop++;
      if (first) begin
        chk("in_rdy_before_first_edge", bus.in_rdy, 0);
        first = 0;
      end else begin
        chk("in_rdy_vs_level", bus.in_rdy, (fifo_lvl != DEPTH));
      end
      chk("fifo_lvl", fifo_lvl, n_acc - n_pop);

      if (bus.aer_req && !prev_req) begin
        chk("setup_cycles", setup_run, SETUP_CYC);
        chk("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("aer_addr_order", bus.aer_addr, exp_q.pop_front());
        hi_cnt = 0;
        acked  = 0;
      end
      if (bus.aer_req) begin
        hi_cnt++;
        if (bus.aer_ack) acked = 1;
      end
      if (!bus.aer_req && prev_req) begin
        if (!acked) begin
          chk("timeout_len", hi_cnt, TIMEOUT);
          exp_err = 1;
          if (exp_drop < 255) exp_drop++;
        end
        chk("timeout_err", timeout_err, exp_err);
        chk("drop_cnt", drop_cnt, exp_drop);
      end
      setup_run  = (dbg_state == 2'd1) ? setup_run + 1 : 0;
      prev_req   = bus.aer_req;
      prev_state = dbg_state;
      pend       = bus.in_vld && bus.in_rdy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_32);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input int max_wait, output bit ok);
    ok = 0;
    bus.in_vld  = 1'b1;
    bus.in_addr = a;
    for (int i = 0; i <= max_wait && !ok; i++) begin
      if (bus.in_rdy) begin
        exp_q.push_back(a);
        ok = 1;
      end
      tick();
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic send_must(input logic [31:0] a);
    bit ok;
    send(a, 300, ok);
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      if (exp_q.size() == 0 && fifo_lvl == 0 && dbg_state == 2'd0 &&
          !bus.aer_req && !bus.aer_ack) done = 1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles, %0d events undelivered", name, limit, exp_q.size());
    end
  endtask

  task automatic clear_err();
    err_clr  = 1'b1;
    exp_err  = 0;
    exp_drop = 0;
    tick();
    err_clr = 1'b0;
    chk("err_clr_flag", timeout_err, 0);
    chk("err_clr_cnt", drop_cnt, 0);
  endtask

  task automatic release_reset();
    @(posedge clk_32);
    #2 rst_n = 1'b1;
    tick();
    chk("in_rdy_after_reset", bus.in_rdy, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int acc, n;
    bus.in_vld  = 1'b0;
    bus.in_addr = '0;

    // Reset values
    repeat (3) @(posedge clk_32);
    #1;
    chk("rst_req", bus.aer_req, 0);
    chk("rst_addr", bus.aer_addr, 0);
    chk("rst_rdy", bus.in_rdy, 0);
    chk("rst_lvl", fifo_lvl, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_state", dbg_state, 0);
    release_reset();

    // Single event
    dev_dly = 2;
    send_must(32'hDEADBEEF);
    wait_idle("single", 100);
    chk("single_addr_hold", bus.aer_addr, 32'hDEADBEEF);
    chk("single_err", timeout_err, 0);

    // Push and pop in the same cycle at level 1
    send_must(32'h1111_0001);
    send_must(32'h1111_0002);
    chk("pushpop_lvl", fifo_lvl, 1);
    wait_idle("pushpop", 200);

    // Randomised traffic with a responsive device
    for (int i = 0; i < 150; i++) begin
      dev_dly = $urandom_range(0, 4);
      repeat ($urandom_range(0, 3)) tick();
      send_must($urandom);
    end
    wait_idle("random", 3000);

    // Fill with a stalled device: 9 accepted (8 queued + 1 in flight)
    dev_on = 0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'hF000_0000 + 32'(i), 0, ok);
      acc += int'(ok);
    end
    chk("fill_accepts", acc, 9);
    chk("fill_lvl", fifo_lvl, DEPTH);
    chk("fill_rdy", bus.in_rdy, 0);
    dev_on = 1;
    wait_idle("fill_drain", 1000);

    // Timeout, then a normal event keeps the sticky flag
    clear_err();
    dev_on = 0;
    send_must(32'hA5A5_0001);
    wait_idle("timeout", 200);
    chk("to_err", timeout_err, 1);
    chk("to_drop", drop_cnt, 1);
    dev_on = 1;
    send_must(32'h0BAD_F00D);
    wait_idle("after_timeout", 200);
    chk("sticky_err", timeout_err, 1);
    chk("sticky_drop", drop_cnt, 1);

    // err_clr in the same cycle as a timeout: the set wins
    dev_on = 0;
    send_must(32'hC0DE_0001);
    n = 0;
    while (!bus.aer_req && n < 20) begin tick(); n++; end
    chk("sim_req_seen", bus.aer_req, 1);
    repeat (TIMEOUT - 1) tick();
    err_clr  = 1'b1;
    exp_err  = 0;
    exp_drop = 0;
    tick();
    err_clr = 1'b0;
    chk("sim_req_fell", bus.aer_req, 0);
    chk("sim_err", timeout_err, 1);
    chk("sim_drop", drop_cnt, 1);
    wait_idle("simultaneous", 100);
    clear_err();

    // Reset while in REQ with three events queued
    for (int i = 0; i < 4; i++) send_must(32'h5EE0_0000 + 32'(i));
    n = 0;
    while (!bus.aer_req && n < 20) begin tick(); n++; end
    chk("mid_req_seen", bus.aer_req, 1);
    chk("mid_lvl", fifo_lvl, 3);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_req", bus.aer_req, 0);
    chk("async_rst_lvl", fifo_lvl, 0);
    chk("async_rst_state", dbg_state, 0);
    repeat (2) @(posedge clk_32);
    dev_on = 1;
    release_reset();
    repeat (5) tick();
    chk("no_stale_req", bus.aer_req, 0);
    send_must(32'h1234_5678);
    wait_idle("after_reset", 200);

    // Drop counter saturation
    dev_on = 0;
    for (int i = 0; i < 260; i++) send_must(32'h5A70_0000 + 32'(i));
    wait_idle("saturation", 20000);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_err", timeout_err, 1);
    dev_on = 1;
    clear_err();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aer_out_4ph.md
Name: aer_out_4ph

Overview:
- Downstream stage of the SpiNNaker-to-neuromorphic bridge.
- Consumes the 32-bit output AER valid/ready stream (oaer_addr/oaer_vld/oaer_rdy) from the bridge top level.
- Buffers events in a small FIFO and drives them onto an external asynchronous 4-phase AER bus (address + req, ack returned from the device).
- Handles ack synchronisation, address setup time, and a handshake timeout with a sticky error flag and a drop counter.

Parameters:
ADDR_W, 32, width of external AER address bus; the low ADDR_W bits of in_addr are driven; 1..32.
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries.
SETUP_CYC, 2, clk_32 edges between aer_addr update and aer_req rise; must be at least 1.
TIMEOUT, 1023, clk_32 cycles in REQ without synchronised ack before the event is dropped; at least 4; counter 16 bits.

Ports:
clk_32  in  1  single clock for all logic.
rst  in  1  asynchronous, active-low reset.
in_addr  in  32  event address from the bridge oaer_addr.
in_vld  in  1  event valid.
in_rdy  out  1  FIFO can accept; transfer on in_vld && in_rdy at a rising edge.
aer_addr  out  ADDR_W  external AER address; registered.
aer_req  out  1  4-phase request; registered.
aer_ack  in  1  4-phase acknowledge; asynchronous, 2-flop synchronised internally (ack_s).
err_clr  in  1  synchronous clear of timeout_err and drop_cnt.
timeout_err  out  1  sticky; set on any handshake timeout.
drop_cnt  out  8  saturating count of timed-out events.
fifo_lvl  out  FIFO_AW+1  current FIFO occupancy.
dbg_state  out  2  FSM state: IDLE=0, SETUP=1, REQ=2, RELEASE=3.

Behaviour:
- Reset (rst low, asynchronous):
  - aer_req=0, aer_addr=0, in_rdy=0 while asserted; in_rdy=1 from the first edge after release.
  - FIFO empty, fifo_lvl=0, timeout_err=0, drop_cnt=0, state IDLE, synchroniser flops 0.
  - Reset mid-handshake drops aer_req immediately and discards the in-flight event and all buffered events.
- FIFO:
  - in_rdy = (fifo_lvl != 2**FIFO_AW), decoded from registered occupancy with no combinational path from in_vld.
  - Push and pop in the same cycle leave fifo_lvl unchanged.
  - Pointers wrap modulo depth.
  - When full, in_rdy=0; it returns to 1 one cycle after a pop.
- IDLE: if FIFO not empty, pop the head; at that edge aer_addr <= head[ADDR_W-1:0], setup counter <= SETUP_CYC, go to SETUP. An event pushed into an empty FIFO at edge N is popped at edge N+1.
- SETUP: counter decrements each cycle. When it reaches 0, assert aer_req, clear timeout counter, go to REQ. aer_req therefore rises exactly SETUP_CYC edges after aer_addr changes.
- REQ:
  - If ack_s=1: aer_req <= 0, go to RELEASE.
  - Otherwise increment the timeout counter. On reaching TIMEOUT: aer_req <= 0, timeout_err <= 1, drop_cnt += 1 (saturate at 255), go to RELEASE. The event is not retried.
- RELEASE: wait for ack_s=0, with no timeout; then go to IDLE. A back-to-back pop may occur on the IDLE cycle that follows.
- aer_addr holds its last value outside handshakes and only changes on a pop.
- Throughput, fast-ack device with 2-cycle sync, SETUP_CYC=2: one event per 2+2+3+3 cycles, roughly 10.
- If err_clr and a timeout occur in the same cycle, the set wins: timeout_err=1 and drop_cnt=1.
- aer_ack is ignored in IDLE and SETUP. If ack_s is already high on entering REQ, the handshake completes on the next cycle (protocol violation tolerated, not flagged).

Test Plan:
- Single event: push 0xDEADBEEF into the empty FIFO, device acks 3 cycles after req rises and releases 3 cycles after req falls. Required: aer_addr=0xDEADBEEF, aer_req rises 2 edges later, 4-phase completes, state returns to IDLE, fifo_lvl=0, no error.
- Fill: hold aer_ack=0 and push 10 events with FIFO_AW=3. Required: in_rdy drops after 9 accepts (8 in the FIFO, 1 in flight) and fifo_lvl=8. Then enable acks: all 9 events appear on aer_addr in push order.
- Timeout: never ack, TIMEOUT=1023. Required: aer_req falls 1023 cycles after rising, timeout_err=1, drop_cnt=1. Then ack a second event normally: it is delivered and timeout_err stays 1 until err_clr.
- Simultaneous: push while popping at fifo_lvl=1. Required: fifo_lvl stays 1. Assert err_clr in the same cycle as a timeout. Required: timeout_err=1, drop_cnt=1.
- Reset mid-operation: assert rst while in REQ with 3 events queued. Required: aer_req=0 asynchronously, fifo_lvl=0. After release, no stale event is emitted and the first new push is delivered correctly.
- Saturation: force 260 timeouts. Required: drop_cnt=255.
